// File: rtl/mem_pkg.sv
// mem_pkg: shared line/beat geometry and FSM/owner encodings for mem_arbiter.
package mem_pkg;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: beat counter, line buffer and per-beat pmem write data.
module cacheline_adaptor #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic              load_i,
    input  logic [LINE_W-1:0] wline_i,
    input  logic [BEAT_W-1:0] pmem_rdata_i,
    input  logic              pmem_resp_i,
    output logic [BEAT_W-1:0] pmem_wdata_o,
    output logic [LINE_W-1:0] line_o,
    output logic              last_o
);
    localparam int NB = LINE_W / BEAT_W;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              beat;
    always_comb begin
        beat   = pmem_resp_i && (rd_i || wr_i);
        last_o = beat && (cnt_q == CW'(NB - 1));
        cnt_d  = last_o ? '0 : (beat ? cnt_q + 1'b1 : cnt_q);
        line_d = line_q;
        if (load_i)
            line_d = wline_i;
        else if (rd_i && pmem_resp_i)
            line_d[cnt_q*BEAT_W +: BEAT_W] = pmem_rdata_i;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end
    assign pmem_wdata_o = line_q[cnt_q*BEAT_W +: BEAT_W];
    assign line_o       = line_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants I/D cache line bursts to physical memory; D wins by default,
// defining MEM_ARB_ROUND_ROBIN_EN alternates grants on simultaneous requests.
module mem_arbiter #(
    parameter int LINE_W = mem_pkg::LINE_W,
    parameter int BEAT_W = mem_pkg::BEAT_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    import mem_pkg::*;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
    logic              d_req, any_req, gnt_d, grant, load, last;
    logic [LINE_W-1:0] line;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e            last_q, last_d;
`endif
    always_comb begin
        d_req    = dcache_read || dcache_write;
        any_req  = d_req || icache_read;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        gnt_d    = d_req && (!icache_read || last_q == OWN_I);
        last_d   = grant ? owner_d : last_q;
`else
        gnt_d    = d_req;
`endif
        grant    = (state_q == IDLE) && any_req;
        sel_addr = gnt_d ? dcache_addr : icache_addr;
        owner_d  = grant ? (gnt_d ? OWN_D : OWN_I) : owner_q;
        addr_d   = grant ? (sel_addr & ~OFF_MASK) : addr_q;
        load     = grant && gnt_d && dcache_write;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_I;
            addr_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= OWN_I;
`endif
        end else begin
            owner_q <= owner_d;
            addr_q  <= addr_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end
    // a simultaneous read+write from the D-cache is a writeback
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:               if (any_req) state_d = (gnt_d && dcache_write) ? WR_BURST : RD_BURST;
            RD_BURST, WR_BURST: if (last) state_d = DONE;
            default:            state_d = IDLE;
        endcase
    end
    always_comb begin
        pmem_read    = state_q == RD_BURST;
        pmem_write   = state_q == WR_BURST;
        pmem_address = addr_q;
        icache_resp  = (state_q == DONE) && (owner_q == OWN_I);
        dcache_resp  = (state_q == DONE) && (owner_q == OWN_D);
        icache_rdata = line;
        dcache_rdata = line;
    end
    cacheline_adaptor #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_adaptor (
        .clk         (clk),
        .rst         (rst),
        .rd_i        (pmem_read),
        .wr_i        (pmem_write),
        .load_i      (load),
        .wline_i     (dcache_wdata),
        .pmem_rdata_i(pmem_rdata),
        .pmem_resp_i (pmem_resp),
        .pmem_wdata_o(pmem_wdata),
        .line_o      (line),
        .last_o      (last)
    );
endmodule
